// File: rtl/hlsm_pkg.sv
// hlsm_pkg: shared types and constants for the scheduled-datapath helpers.
// Holds the shared-adder FSM state encoding, the default operand width and
// the signed saturation limits that follow from that width.
package hlsm_pkg;

    localparam int HLSM_DATA_W = 16;

    // Signed limits for the default width; the adder derives its own from its parameter.
    localparam logic [HLSM_DATA_W-1:0] HLSM_SAT_MAX = {1'b0, {(HLSM_DATA_W-1){1'b1}}};
    localparam logic [HLSM_DATA_W-1:0] HLSM_SAT_MIN = {1'b1, {(HLSM_DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin pick.
// The search starts at i_ptr and walks upward modulo N_REQ; the first active
// request wins. The pointer register is owned by the parent.
module rr_arbiter
    import hlsm_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic [N_REQ-1:0]         o_gnt_oh,
    output logic [$clog2(N_REQ)-1:0] o_idx,
    output logic                     o_vld
);

    localparam int IDW = $clog2(N_REQ);

    // Scan from the pointer and keep only the first active requester.
    always_comb begin
        o_gnt_oh = '0;
        o_idx    = '0;
        o_vld    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!o_vld && i_req[(int'(i_ptr) + i) % N_REQ]) begin
                o_vld                                   = 1'b1;
                o_gnt_oh[(int'(i_ptr) + i) % N_REQ]     = 1'b1;
                o_idx                                   = IDW'((int'(i_ptr) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/add_share_arbiter.sv
// add_share_arbiter: one signed adder shared by N_REQ requesters.
// Handshake: a requester holds req[k] until it sees the one-cycle gnt[k]
// pulse; operands are captured at the grant edge, and exactly one
// res_valid pulse tagged with res_id follows one cycle after gnt.
// Build option: define ADD_SAT_EN for signed saturation instead of wrap.
module add_share_arbiter
    import hlsm_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = HLSM_DATA_W
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   opa,
    input  logic [N_REQ*DATA_W-1:0]   opb,
    output logic [N_REQ-1:0]          gnt,
    output logic [DATA_W-1:0]         res,
    output logic                      res_valid,
    output logic [$clog2(N_REQ)-1:0]  res_id,
    output logic                      busy,
    output logic [1:0]                dbg_state
);

    localparam int IDW = $clog2(N_REQ);

    state_t             r_state;
    state_t             w_state_next;
    logic [IDW-1:0]     r_ptr;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic [DATA_W-1:0]  w_res;
    logic               w_grant;
    logic [N_REQ-1:0]   w_win_oh;
    logic [IDW-1:0]     w_win_idx;
    logic               w_win_vld;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_gnt_oh (w_win_oh),
        .o_idx    (w_win_idx),
        .o_vld    (w_win_vld)
    );

    // Next state: arbitrate in IDLE and RESP, EXEC always moves on to RESP.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_win_vld) begin
                    w_grant      = 1'b1;
                    w_state_next = EXEC;
                end
            end
            EXEC: begin
                w_state_next = RESP;
            end
            RESP: begin
                if (w_win_vld) begin
                    w_grant      = 1'b1;
                    w_state_next = EXEC;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

`ifdef ADD_SAT_EN
    localparam logic [DATA_W-1:0] L_SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] L_SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    logic [DATA_W:0] w_sum_ext;

    // Add with one guard bit; a guard/sign disagreement means overflow, clamp by direction.
    always_comb begin
        w_sum_ext = {r_a[DATA_W-1], r_a} + {r_b[DATA_W-1], r_b};
        if (w_sum_ext[DATA_W] != w_sum_ext[DATA_W-1]) begin
            w_res = w_sum_ext[DATA_W] ? L_SAT_MIN : L_SAT_MAX;
        end else begin
            w_res = w_sum_ext[DATA_W-1:0];
        end
    end
`else
    // Plain two's-complement add, wrapping like the existing datapaths.
    always_comb begin
        w_res = r_a + r_b;
    end
`endif

    // State, pointer, operand capture and the gnt/res_valid pulses.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            gnt       <= '0;
            res       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
        end else begin
            r_state   <= w_state_next;
            gnt       <= '0;
            res_valid <= 1'b0;
            if (w_grant) begin
                gnt    <= w_win_oh;
                r_a    <= opa[w_win_idx*DATA_W +: DATA_W];
                r_b    <= opb[w_win_idx*DATA_W +: DATA_W];
                res_id <= w_win_idx;
                r_ptr  <= (w_win_idx == IDW'(N_REQ-1)) ? '0 : w_win_idx + 1'b1;
            end
            if (r_state == EXEC) begin
                res       <= w_res;
                res_valid <= 1'b1;
            end
        end
    end

    assign busy      = (r_state == EXEC) || (r_state == RESP);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_add_share_arbiter.sv
// tb_add_share_arbiter: directed scenarios plus randomized traffic for the
// shared adder, checked every cycle against a behavioural model.
module tb_add_share_arbiter;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int IDW = 2;

`ifdef ADD_SAT_EN
  localparam logic [DW-1:0] OV_POS = 16'h7FFF;
  localparam logic [DW-1:0] OV_NEG = 16'h8000;
`else
  localparam logic [DW-1:0] OV_POS = 16'h8000;
  localparam logic [DW-1:0] OV_NEG = 16'h7FFF;
`endif

  // ---------------- clock / reset ----------------
  logic            Clk = 1'b0;
  logic            Rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] opa = '0;
  logic [N*DW-1:0] opb = '0;
  logic [N-1:0]    gnt;
  logic [DW-1:0]   res;
  logic            res_valid;
  logic [IDW-1:0]  res_id;
  logic            busy;
  logic [1:0]      dbg_state;

  always #5 Clk = ~Clk;

  add_share_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .req       (req),
    .opa       (opa),
    .opb       (opb),
    .gnt       (gnt),
    .res       (res),
    .res_valid (res_valid),
    .res_id    (res_id),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Rules: arbitration happens on any edge that does not directly follow a
  // grant; the winner is the first active requester at or above the pointer
  // (mod N); its sum appears one edge after the grant.
  int              m_ptr      = 0;
  bit              m_cool     = 1'b0;
  bit              m_pend_v   = 1'b0;
  logic [DW-1:0]   m_pend_sum = '0;
  logic [N-1:0]    exp_gnt    = '0;
  logic            exp_rv     = 1'b0;
  logic            exp_busy   = 1'b0;
  logic [DW-1:0]   exp_res    = '0;
  logic [IDW-1:0]  exp_id     = '0;
  logic [IDW+DW-1:0] exp_q[$];

  function automatic logic [DW-1:0] model_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
`ifdef ADD_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return s[DW-1:0];
  endfunction

  task automatic model_step();
    int w;
    int k;
    logic [IDW-1:0] wid;
    if (Rst) begin
      m_ptr = 0; m_cool = 1'b0; m_pend_v = 1'b0;
      exp_gnt = '0; exp_rv = 1'b0; exp_res = '0; exp_id = '0;
      exp_q.delete();
    end else begin
      exp_rv = m_pend_v;
      if (m_pend_v) exp_res = m_pend_sum;
      m_pend_v = 1'b0;
      exp_gnt = '0;
      if (m_cool) begin
        m_cool = 1'b0;
      end else if (req != '0) begin
        w = -1;
        for (int i = 0; i < N; i++) begin
          k = (m_ptr + i) % N;
          if (w < 0 && req[k]) w = k;
        end
        wid = IDW'(w);
        exp_gnt[w] = 1'b1;
        exp_id     = wid;
        m_pend_sum = model_add(opa[w*DW +: DW], opb[w*DW +: DW]);
        m_pend_v   = 1'b1;
        m_ptr      = (w + 1) % N;
        m_cool     = 1'b1;
        exp_q.push_back({wid, m_pend_sum});
      end
    end
    exp_busy = m_cool || exp_rv;
  endtask

  // Per-cycle comparison of every output against the model plus scoreboard.
  always @(posedge Clk) begin
    logic [IDW+DW-1:0] e;
    model_step();
    #1;
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("res_valid", 32'(res_valid), 32'(exp_rv));
    check("busy", 32'(busy), 32'(exp_busy));
    check("res", 32'(res), 32'(exp_res));
    check("res_id", 32'(res_id), 32'(exp_id));
    check("gnt_rv_excl", 32'((|gnt) && res_valid), 32'd0);
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", 32'({res_id, res}), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_ops(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
    opa[k*DW +: DW] = a;
    opb[k*DW +: DW] = b;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [DW-1:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // One transaction from idle: checks grant/result latency and the value.
  task automatic single_txn(input string tag, input int k, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input logic [DW-1:0] exp_val);
    int glat;
    int rlat;
    @(negedge Clk);
    set_ops(k, a, b);
    req = '0;
    req[k] = 1'b1;
    glat = 0;
    for (int c = 1; c <= 8 && glat == 0; c++) begin
      @(posedge Clk); #2;
      if (gnt[k]) glat = c;
    end
    check({tag, "_gnt_lat"}, 32'(glat), 32'd1);
    @(negedge Clk);
    req = '0;
    rlat = 0;
    for (int c = 1; c <= 8 && rlat == 0; c++) begin
      @(posedge Clk); #2;
      if (res_valid) rlat = c;
    end
    check({tag, "_res_lat"}, 32'(rlat), 32'd1);
    check({tag, "_res"}, 32'(res), 32'(exp_val));
    check({tag, "_id"}, 32'(res_id), 32'(k));
    idle(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int gi[$];
    int gc[$];
    int first1;
    bit seen;

    repeat (3) @(negedge Clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_res", 32'(res), 32'd0);
    check("rst_rv", 32'(res_valid), 32'd0);
    check("rst_id", 32'(res_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    Rst = 1'b0;
    idle(2);

    // single request: 7 + -12 = -5
    single_txn("single", 0, 16'd7, 16'hFFF4, 16'hFFFB);

    // all four requesting continuously out of reset
    @(negedge Clk);
    Rst = 1'b1;
    req = '1;
    for (int k = 0; k < N; k++) set_ops(k, 16'($urandom), 16'($urandom));
    idle(2);
    Rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge Clk); #2;
      if (|gnt) begin
        gi.push_back(oh_idx(gnt));
        gc.push_back(c);
      end
    end
    check("rr_count", 32'(gi.size()), 32'd5);
    for (int i = 0; i < gi.size() && i < 5; i++) begin
      check("rr_order", 32'(gi[i]), 32'(i % N));
      if (i > 0) check("rr_gap", 32'(gc[i] - gc[i-1]), 32'd2);
    end
    @(negedge Clk);
    req = '0;
    idle(4);

    // overflow in both directions
    single_txn("ovf_pos", 1, 16'h7FFF, 16'h0001, OV_POS);
    single_txn("ovf_neg", 3, 16'h8000, 16'hFFFF, OV_NEG);

    // reset pulse during EXEC aborts the transaction
    @(negedge Clk);
    set_ops(2, 16'd100, 16'd23);
    req = 4'b0100;
    @(posedge Clk); #2;
    check("abort_gnt", 32'(gnt), 32'h4);
    @(negedge Clk);
    Rst = 1'b1;
    req = '0;
    @(posedge Clk); #2;
    check("abort_gnt0", 32'(gnt), 32'd0);
    check("abort_res0", 32'(res), 32'd0);
    check("abort_rv0", 32'(res_valid), 32'd0);
    check("abort_id0", 32'(res_id), 32'd0);
    check("abort_busy0", 32'(busy), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge Clk); #2;
      if (res_valid || (|gnt)) seen = 1'b1;
    end
    check("abort_quiet", 32'(seen), 32'd0);
    @(negedge Clk);
    req = '1;
    @(posedge Clk); #2;
    check("abort_ptr0", 32'(gnt), 32'h1);
    @(negedge Clk);
    req = '0;
    idle(4);

    // fairness against a hog on req[2]
    set_ops(1, 16'd5, 16'd6);
    set_ops(2, 16'd1000, 16'hFF00);
    req = 4'b0100;
    idle(5);
    req = 4'b0110;
    gi.delete();
    for (int c = 0; c < 14; c++) begin
      @(posedge Clk); #2;
      if (|gnt) gi.push_back(oh_idx(gnt));
    end
    @(negedge Clk);
    req = '0;
    first1 = -1;
    for (int i = 0; i < gi.size(); i++) if (first1 < 0 && gi[i] == 1) first1 = i;
    check("hog_wait", 32'(first1 >= 0 && first1 <= 1), 32'd1);
    check("hog_count", 32'(gi.size() >= 6), 32'd1);
    for (int i = (first1 < 0 ? gi.size() : first1 + 1); i < gi.size(); i++)
      check("hog_alternate", 32'(gi[i] != gi[i-1]), 32'd1);
    idle(4);

    // withdrawal: req[3] pulses only while req[0] is being served
    set_ops(0, 16'd11, 16'd22);
    set_ops(3, 16'd33, 16'd44);
    req = 4'b0001;
    @(posedge Clk); #2;
    @(negedge Clk);
    req = 4'b1000;
    seen = 1'b0;
    @(posedge Clk); #2;
    if (gnt[3]) seen = 1'b1;
    @(negedge Clk);
    req = '0;
    repeat (8) begin
      @(posedge Clk); #2;
      if (gnt[3]) seen = 1'b1;
    end
    check("withdraw_no_gnt3", 32'(seen), 32'd0);
    idle(2);

    // randomized traffic with operand churn and rare resets
    for (int c = 0; c < 400; c++) begin
      @(negedge Clk);
      Rst = ($urandom_range(0, 59) == 0);
      req = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
      for (int k = 0; k < N; k++) set_ops(k, pick_val(), pick_val());
    end
    @(negedge Clk);
    Rst = 1'b0;
    req = '0;
    idle(6);
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
